// File: rtl/vmem_arb_pkg.sv
// rtl/vmem_arb_pkg.sv - shared types, constants and round-robin pick for the vmem arbiter
package vmem_arb_pkg;

    localparam int ARB_NREQ    = 2;
    localparam int VMEM_ADDR_W = 32;

    typedef logic [$clog2(ARB_NREQ)-1:0] req_idx_t;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_e;

    // Scans downward so the final assignment is the nearest requester at or above prio.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] prio,
                                           input int nreq);
        logic [1:0] pick;
        int         idx;
        pick = prio;
        for (int i = 3; i >= 0; i--) begin
            if (i < nreq) begin
                idx = (int'(prio) + i) % nreq;
                if (req[idx[1:0]]) pick = idx[1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/vmem_arb_id_fifo.sv
// rtl/vmem_arb_id_fifo.sv - in-order FIFO of requester indices for granted transactions
module vmem_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - round-robin sharing of one in-order vector-memory port among requesters
module vmem_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int VMEM_W    = 128,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NREQ-1:0]                req_i,
    output logic [NREQ-1:0]                gnt_o,
    input  logic [NREQ*32-1:0]             addr_i,
    input  logic [NREQ-1:0]                we_i,
    input  logic [NREQ*VMEM_W/8-1:0]       be_i,
    input  logic [NREQ*VMEM_W-1:0]         wdata_i,
    output logic [NREQ-1:0]                rvalid_o,
    output logic [VMEM_W-1:0]              rdata_o,
    output logic                           err_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [31:0]                    mem_addr_o,
    output logic                           mem_we_o,
    output logic [VMEM_W/8-1:0]            mem_be_o,
    output logic [VMEM_W-1:0]              mem_wdata_o,
    input  logic                           mem_rvalid_i,
    input  logic [VMEM_W-1:0]              mem_rdata_i,
    input  logic                           mem_err_i,
    output logic [$clog2(MAX_OUTST):0]     outst_o,
    output logic                           idle_o,
    output logic                           proto_err_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = VMEM_W / 8;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] lock_q, lock_d;
    logic [IW-1:0] prio_q, prio_d;
    logic [IW-1:0] sel;
    logic [IW-1:0] head;
    logic          full;
    logic          empty;
    logic          grant;
    logic          pop;
    logic          proto_q;

    assign sel = (state_q == ARB_LOCKED) ? lock_q
                                         : IW'(rr_pick(4'(req_i), 2'(prio_q), NREQ));

    // A locked requester is still holding its request, so lock alone keeps mem_req up.
    assign mem_req_o = !full && ((state_q == ARB_LOCKED) || (|req_i));
    assign grant     = mem_req_o && mem_gnt_i;
    assign pop       = mem_rvalid_i && !empty;

    assign mem_addr_o  = addr_i[int'(sel)*VMEM_ADDR_W +: VMEM_ADDR_W];
    assign mem_we_o    = we_i[sel];
    assign mem_be_o    = be_i[int'(sel)*BW +: BW];
    assign mem_wdata_o = wdata_i[int'(sel)*VMEM_W +: VMEM_W];

    assign rdata_o     = mem_rdata_i;
    assign err_o       = mem_err_i;
    assign proto_err_o = proto_q;
    assign idle_o      = (outst_o == '0) && !(|req_i);

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (grant) gnt_o[sel]    = 1'b1;
        if (pop)   rvalid_o[head] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        prio_d  = prio_q;
        if (grant) begin
            state_d = ARB_OPEN;
            prio_d  = (int'(sel) == NREQ - 1) ? '0 : sel + IW'(1);
        end else if (mem_req_o) begin
            state_d = ARB_LOCKED;
            lock_d  = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_OPEN;
            lock_q  <= '0;
            prio_q  <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            prio_q  <= prio_d;
            if (mem_rvalid_i && empty) proto_q <= 1'b1;
        end
    end

    vmem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IW)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (grant),
        .din   (sel),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outst_o)
    );

endmodule
